// File: rtl/divider_pkg.sv
// Shared types for the queued divider: engine state encoding and request-queue entry.
// Entry fields are sized for the widest supported configuration; narrower
// instances zero-extend on push and slice on pop.
package divider_pkg;

    // Upper bounds for C_WIDTH and TAG_WIDTH accepted by divider_queued.
    localparam int DIV_MAX_WIDTH = 64;
    localparam int DIV_MAX_TAG   = 16;

    // Division engine states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    // One queued request.
    typedef struct packed {
        logic [DIV_MAX_WIDTH-1:0] a;
        logic [DIV_MAX_WIDTH-1:0] b;
        logic                     signed_cal;
        logic [DIV_MAX_TAG-1:0]   tag;
    } div_entry_t;

endpackage

// File: rtl/divider_fifo.sv
// Request queue: synchronous FIFO of div_entry_t with an occupancy count.
// Latency: a pushed entry is visible at dout on the next cycle; dout is not registered.
// Backpressure: pushes while full and pops while empty are ignored; push+pop together are both honoured.
module divider_fifo
    import divider_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  div_entry_t             din,
    input  logic                   pop,
    output div_entry_t             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    div_entry_t     mem_q [DEPTH];
    div_entry_t     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_ok, pop_ok;

    assign push_ok = push && (count_q < CW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/divider_queued.sv
// Queued radix-2 restoring divider (unsigned/signed, optional fixed-point fraction); DIVIDER_DZ_DETECT_EN enables divide-by-zero bypass.
// Latency: done N+2 edges after accept (N = C_WIDTH+FRAC_BITS), 2 edges on a detected divide-by-zero; one result per N+2 cycles back-to-back.
// Backpressure: ready drops when the FIFO_DEPTH-entry queue is full; a trigger while ready=0 is dropped.
module divider_queued
    import divider_pkg::*;
#(
    parameter int C_WIDTH    = 16,
    parameter int FRAC_BITS  = 0,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 ctl_clk,
    input  logic                 reset,
    input  logic [C_WIDTH-1:0]   a,
    input  logic [C_WIDTH-1:0]   b,
    input  logic                 signed_cal,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 trigger,
    output logic                 ready,
    output logic [C_WIDTH-1:0]   q,
    output logic [C_WIDTH-1:0]   r,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 done,
    output logic                 busy,
    output logic                 dz
);

`ifdef DIVIDER_DZ_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    localparam int N    = C_WIDTH + FRAC_BITS;
    localparam int IW   = $clog2(N) + 1;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [C_WIDTH-1:0] MOST_NEG = {1'b1, {(C_WIDTH-1){1'b0}}};
    localparam logic [C_WIDTH-1:0] MAX_POS  = {1'b0, {(C_WIDTH-1){1'b1}}};

    // ---------------- request queue ----------------
    div_entry_t        push_entry;
    div_entry_t        head;
    logic [CNTW-1:0]   fifo_count;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign ready = (fifo_count < CNTW'(FIFO_DEPTH));
    assign push  = trigger && ready;

    always_comb begin
        push_entry            = '0;
        push_entry.a          = DIV_MAX_WIDTH'(a);
        push_entry.b          = DIV_MAX_WIDTH'(b);
        push_entry.signed_cal = signed_cal;
        push_entry.tag        = DIV_MAX_TAG'(tag_in);
    end

    divider_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ctl_clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // ---------------- head decode: magnitudes and signs ----------------
    logic [C_WIDTH-1:0]   h_a, h_b, h_ua, h_ub;
    logic [TAG_WIDTH-1:0] h_tag;
    logic                 h_s, h_an, h_bn, h_bz;
    logic [N-1:0]         dq_init;

    assign h_a   = head.a[C_WIDTH-1:0];
    assign h_b   = head.b[C_WIDTH-1:0];
    assign h_s   = head.signed_cal;
    assign h_tag = head.tag[TAG_WIDTH-1:0];
    assign h_an  = h_s & h_a[C_WIDTH-1];
    assign h_bn  = h_s & h_b[C_WIDTH-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign h_ua  = h_an ? -h_a : h_a;
    assign h_ub  = h_bn ? -h_b : h_b;
    assign h_bz  = (h_b == '0);

    // Scaled dividend: magnitude shifted up by the fraction bits.
    always_comb begin
        dq_init                  = '0;
        dq_init[N-1 -: C_WIDTH]  = h_ua;
    end

    // ---------------- FSM ----------------
    div_state_t state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          iter_last;
    logic          load, step, finish;

    assign iter_last = (iter_q == IW'(N - 1));

    // State register.
    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero divisor skips the iteration phase when detection is built in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = (DZ_EN && h_bz) ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                if (iter_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        pop    = (state_q == ST_IDLE) && !fifo_empty;
        load   = pop;
        step   = (state_q == ST_CALC);
        finish = (state_q == ST_FIX);
    end

    // ---------------- datapath ----------------
    logic [C_WIDTH-1:0]   rem_q, rem_d;
    logic [N-1:0]         dq_q, dq_d;
    logic [C_WIDTH-1:0]   ub_q, ub_d;
    logic [C_WIDTH-1:0]   a_q, a_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 sc_q, sc_d;
    logic                 dzp_q, dzp_d;
    logic [TAG_WIDTH-1:0] wtag_q, wtag_d;

    logic [C_WIDTH-1:0]   q_q, q_d;
    logic [C_WIDTH-1:0]   r_q, r_d;
    logic [TAG_WIDTH-1:0] tag_out_q, tag_out_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    logic [C_WIDTH:0]     trial, sub;
    logic                 ge;
    logic [C_WIDTH-1:0]   q_mag, q_res, r_res, dz_qval;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial = {rem_q, dq_q[N-1]};
    assign sub   = trial - {1'b0, ub_q};
    assign ge    = (trial >= {1'b0, ub_q});

    // Sign correction and divide-by-zero saturation values.
    assign q_mag   = dq_q[C_WIDTH-1:0];
    assign q_res   = qneg_q ? -q_mag : q_mag;
    assign r_res   = rneg_q ? -rem_q : rem_q;
    assign dz_qval = sc_q ? (a_q[C_WIDTH-1] ? MOST_NEG : MAX_POS) : '1;

    // Datapath next-state: load on pop, iterate in CALC, publish results in FIX.
    always_comb begin
        rem_d     = rem_q;
        dq_d      = dq_q;
        ub_d      = ub_q;
        a_d       = a_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sc_d      = sc_q;
        dzp_d     = dzp_q;
        wtag_d    = wtag_q;
        iter_d    = iter_q;
        q_d       = q_q;
        r_d       = r_q;
        tag_out_d = tag_out_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        if (load) begin
            rem_d  = '0;
            dq_d   = dq_init;
            ub_d   = h_ub;
            a_d    = h_a;
            qneg_d = h_an ^ h_bn;
            rneg_d = h_an;
            sc_d   = h_s;
            dzp_d  = DZ_EN && h_bz;
            wtag_d = h_tag;
            iter_d = '0;
        end

        if (step) begin
            rem_d  = ge ? sub[C_WIDTH-1:0] : trial[C_WIDTH-1:0];
            dq_d   = {dq_q[N-2:0], ge};
            iter_d = iter_q + IW'(1);
        end

        if (finish) begin
            q_d       = dzp_q ? dz_qval : q_res;
            r_d       = dzp_q ? a_q : r_res;
            tag_out_d = wtag_q;
            dz_d      = dzp_q;
            done_d    = 1'b1;
        end
    end

    // Datapath and result registers; reset also discards any in-flight request.
    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            rem_q     <= '0;
            dq_q      <= '0;
            ub_q      <= '0;
            a_q       <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sc_q      <= 1'b0;
            dzp_q     <= 1'b0;
            wtag_q    <= '0;
            iter_q    <= '0;
            q_q       <= '0;
            r_q       <= '0;
            tag_out_q <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            dq_q      <= dq_d;
            ub_q      <= ub_d;
            a_q       <= a_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sc_q      <= sc_d;
            dzp_q     <= dzp_d;
            wtag_q    <= wtag_d;
            iter_q    <= iter_d;
            q_q       <= q_d;
            r_q       <= r_d;
            tag_out_q <= tag_out_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign q       = q_q;
    assign r       = r_q;
    assign tag_out = tag_out_q;
    assign done    = done_q;
    assign dz      = DZ_EN ? dz_q : 1'b0;

    // Queue entries carry upper bits beyond this instance's widths, and the
    // scaled quotient's top fraction bits are discarded.
    logic unused_bits;
    assign unused_bits = ^{head, dq_q};

endmodule

// File: tb/tb_divider_queued.sv
module tb_divider_queued;

`ifdef DIVIDER_DZ_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic       ctl_clk = 1'b0;
    always #5 ctl_clk = ~ctl_clk;

    logic       reset = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic       signed_cal = 1'b0;
    logic [3:0] tag_in = '0;
    logic       trig0 = 1'b0, trig1 = 1'b0;

    logic       ready0, done0, busy0, dz0;
    logic [7:0] q0, r0;
    logic [3:0] tag0;
    logic       ready1, done1, busy1, dz1;
    logic [7:0] q1, r1;
    logic [3:0] tag1;

    int nchk = 0;
    int nerr = 0;

    divider_queued #(.C_WIDTH(8), .FRAC_BITS(0), .TAG_WIDTH(4), .FIFO_DEPTH(4)) u_dut (
        .ctl_clk(ctl_clk), .reset(reset), .a(a), .b(b), .signed_cal(signed_cal),
        .tag_in(tag_in), .trigger(trig0), .ready(ready0), .q(q0), .r(r0),
        .tag_out(tag0), .done(done0), .busy(busy0), .dz(dz0)
    );

    divider_queued #(.C_WIDTH(8), .FRAC_BITS(4), .TAG_WIDTH(4), .FIFO_DEPTH(4)) u_frac (
        .ctl_clk(ctl_clk), .reset(reset), .a(a), .b(b), .signed_cal(signed_cal),
        .tag_in(tag_in), .trigger(trig1), .ready(ready1), .q(q1), .r(r1),
        .tag_out(tag1), .done(done1), .busy(busy1), .dz(dz1)
    );

    // Reference: plain integer arithmetic on the scaled dividend.
    task automatic model(input logic [7:0] av, input logic [7:0] bv, input bit s, input int frac,
                         output logic [7:0] eq, output logic [7:0] er, output bit edz);
        longint x, y, n, qv, rv;
        x = longint'(av);
        y = longint'(bv);
        if (s && av[7]) x = x - 256;
        if (s && bv[7]) y = y - 256;
        if (y == 0) begin
            edz = DZ_EN;
            eq  = s ? ((x < 0) ? 8'h80 : 8'h7f) : 8'hff;
            er  = av;
        end else begin
            edz = 1'b0;
            n   = x * (longint'(1) << frac);
            qv  = n / y;
            rv  = n % y;
            eq  = qv[7:0];
            er  = rv[7:0];
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one request to an idle divider and check latency, result and strobe width.
    task automatic run_one(input bit sel, input logic [7:0] av, input logic [7:0] bv, input bit s,
                           input logic [3:0] t, input string name);
        logic [7:0] eq, er;
        bit         edz;
        int         lat, exp_lat;
        model(av, bv, s, sel ? 4 : 0, eq, er, edz);
        exp_lat = (edz) ? 2 : (sel ? 14 : 10);
        a = av; b = bv; signed_cal = s; tag_in = t;
        if (sel) trig1 = 1'b1; else trig0 = 1'b1;
        @(negedge ctl_clk);
        trig0 = 1'b0; trig1 = 1'b0;
        lat = 0;
        while (!(sel ? done1 : done0) && lat < 64) begin
            @(negedge ctl_clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_q"},   sel ? q1 : q0, eq);
        check({name, "_r"},   sel ? r1 : r0, er);
        check({name, "_tag"}, sel ? tag1 : tag0, t);
        check({name, "_dz"},  sel ? dz1 : dz0, edz);
        @(negedge ctl_clk);
        check({name, "_done1cyc"}, sel ? done1 : done0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ba [6];
        logic [7:0] bb [6];
        bit         bs [6];
        bit         rdy [6];
        logic [7:0] eq, er, rav, rbv;
        bit         edz, rs;
        int         ndone, last_c, dcnt;

        // ---- reset ----
        repeat (3) @(negedge ctl_clk);
        reset = 1'b0;
        check("rst_q", q0, 8'h00);
        check("rst_r", r0, 8'h00);
        check("rst_tag", tag0, 4'h0);
        check("rst_done", done0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_dz", dz0, 1'b0);
        check("rst_ready", ready0, 1'b1);

        // ---- directed unsigned ----
        run_one(0, 8'h0f, 8'h05, 0, 4'h1, "u_0f_05");
        repeat (4) @(negedge ctl_clk);
        check("hold_q", q0, 8'h03);
        check("hold_tag", tag0, 4'h1);
        run_one(0, 8'h35, 8'h05, 0, 4'h2, "u_35_05");

        // ---- directed signed ----
        run_one(0, 8'h05, 8'hfd, 1, 4'h3, "s_05_fd");
        run_one(0, 8'hf9, 8'h02, 1, 4'h4, "s_f9_02");
        run_one(0, 8'h80, 8'hff, 1, 4'h5, "s_80_ff");

        // ---- divide by zero ----
        run_one(0, 8'h12, 8'h00, 0, 4'h6, "u_dz_12");
        if (DZ_EN) begin
            run_one(0, 8'h85, 8'h00, 1, 4'h7, "s_dz_85");
            run_one(0, 8'h05, 8'h00, 1, 4'h8, "s_dz_05");
        end

        // ---- fraction bits ----
        run_one(1, 8'h03, 8'h02, 0, 4'h9, "f_03_02");
        for (int i = 0; i < 4; i++) begin
            rav = 8'($urandom_range(0, 255));
            rbv = 8'($urandom_range(1, 255));
            rs  = 1'($urandom_range(0, 1));
            run_one(1, rav, rbv, rs, 4'(i), "f_rand");
        end

        // ---- random stream ----
        for (int i = 0; i < 16; i++) begin
            rav = 8'($urandom_range(0, 255));
            rbv = (i % 5 == 4) ? 8'h00 : 8'($urandom_range(0, 255));
            rs  = 1'($urandom_range(0, 1));
            if (rs && rbv == 8'h00 && !DZ_EN) rbv = 8'h01;
            run_one(0, rav, rbv, rs, 4'($urandom_range(0, 15)), "rand");
        end

        // ---- burst: trigger held 6 cycles ----
        for (int i = 0; i < 6; i++) begin
            ba[i] = 8'($urandom_range(0, 255));
            bb[i] = 8'($urandom_range(1, 255));
            bs[i] = 1'($urandom_range(0, 1));
            a = ba[i]; b = bb[i]; signed_cal = bs[i]; tag_in = 4'(i);
            trig0 = 1'b1;
            rdy[i] = ready0;
            @(negedge ctl_clk);
        end
        trig0 = 1'b0;
        check("burst_ready5", rdy[4], 1'b1);
        check("burst_ready6", rdy[5], 1'b0);
        ndone = 0;
        last_c = 0;
        for (int c = 0; c < 100; c++) begin
            if (done0) begin
                if (ndone < 5) begin
                    model(ba[ndone], bb[ndone], bs[ndone], 0, eq, er, edz);
                    check("burst_tag", tag0, 4'(ndone));
                    check("burst_q", q0, eq);
                    check("burst_r", r0, er);
                    if (ndone > 0) check("burst_spacing", 64'(c - last_c), 64'd10);
                end
                last_c = c;
                ndone++;
            end
            @(negedge ctl_clk);
        end
        check("burst_count", 64'(ndone), 64'd5);

        // ---- reset during CALC with two requests queued ----
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(1, 255));
            signed_cal = 1'b0; tag_in = 4'(10 + i);
            trig0 = 1'b1;
            @(negedge ctl_clk);
        end
        trig0 = 1'b0;
        check("mid_busy", busy0, 1'b1);
        repeat (2) @(negedge ctl_clk);
        reset = 1'b1;
        @(negedge ctl_clk);
        reset = 1'b0;
        check("mid_q", q0, 8'h00);
        check("mid_r", r0, 8'h00);
        check("mid_tag", tag0, 4'h0);
        check("mid_done", done0, 1'b0);
        check("mid_busy0", busy0, 1'b0);
        check("mid_dz", dz0, 1'b0);
        check("mid_ready", ready0, 1'b1);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ctl_clk);
            if (done0) dcnt++;
        end
        check("mid_no_done", 64'(dcnt), 64'd0);
        check("mid_idle", busy0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
